// File: rtl/pwm_capture_pkg.sv
// -----------------------------------------------------------------------------
// pwm_capture_pkg
//   Shared definitions for the PWM capture block:
//     - register word addresses on the Avalon-MM slave
//     - CONTROL / STATUS bit positions
//     - measurement FSM state encoding
//     - small helpers for byte-enabled writes and saturating counters
// -----------------------------------------------------------------------------
package pwm_capture_pkg;

    // Register word addresses
    localparam logic [2:0] ADDR_PERIOD  = 3'd0;
    localparam logic [2:0] ADDR_HIGH    = 3'd1;
    localparam logic [2:0] ADDR_CONTROL = 3'd2;
    localparam logic [2:0] ADDR_STATUS  = 3'd3;
    localparam logic [2:0] ADDR_TIMEOUT = 3'd4;
    localparam logic [2:0] ADDR_COUNT   = 3'd5;

    // CONTROL bit indices
    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_IRQ_EN = 1;

    // STATUS bit indices
    localparam int STAT_VALID   = 0;
    localparam int STAT_OVERRUN = 1;
    localparam int STAT_TIMEOUT = 2;

    // Measurement FSM states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_HIGH      = 2'd2,
        ST_LOW       = 2'd3
    } state_e;

    // Merge a 32-bit write into an existing value, one byte lane at a time.
    function automatic logic [31:0] apply_be(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// -----------------------------------------------------------------------------
// pwm_capture_if
//   Avalon-MM slave bus bundle for pwm_capture.
//   Signals:
//     chipselect  master->slave  slave select
//     address     master->slave  word address (3 bits)
//     write       master->slave  write strobe
//     writedata   master->slave  write data (32 bits)
//     read        master->slave  read strobe
//     byteenable  master->slave  byte lanes for writes
//     readdata    slave->master  registered read data
//
//   Handshake: there is no waitrequest. A transfer is accepted on every
//   rising clk edge where chipselect is high together with write or read.
//   Writes take effect on that edge; read data appears on readdata one clock
//   later (fixed read latency 1) and is held until the next accepted read.
// -----------------------------------------------------------------------------
interface pwm_capture_if;
    import pwm_capture_pkg::*;

    logic        chipselect;
    logic [2:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    modport master (
        output chipselect, address, write, writedata, read, byteenable,
        input  readdata
    );

    modport slave (
        input  chipselect, address, write, writedata, read, byteenable,
        output readdata
    );

endinterface

// File: rtl/pwm_capture_sync.sv
// -----------------------------------------------------------------------------
// pwm_capture_sync
//   Brings the asynchronous PWM pin into the clk domain and produces
//   single-cycle rise/fall pulses.
//   Ports:
//     clk      in   system clock
//     reset    in   synchronous active-high reset
//     i_pin    in   asynchronous PWM input
//     o_rise   out  one-cycle pulse per rising edge of i_pin
//     o_fall   out  one-cycle pulse per falling edge of i_pin
//   A pin change shows up on o_rise/o_fall SYNC_STAGES+1 clocks later; both
//   edges see the same latency so measured widths are exact. SYNC_STAGES
//   must be at least 2.
// -----------------------------------------------------------------------------
module pwm_capture_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_rise,
    output logic o_fall
);
    import pwm_capture_pkg::*;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sync_out;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_prev <= w_sync_out;
            // Registered pulses: the extra flop is the "+1" in the latency.
            r_rise <= w_sync_out & ~r_prev;
            r_fall <= ~w_sync_out & r_prev;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//   Avalon-MM slave that measures an external PWM signal: period (rise to
//   rise) and high time (rise to fall) in clk cycles.
//   Ports:
//     clk          in   system clock
//     reset        in   synchronous active-high reset
//     avs          --   Avalon-MM slave bus (pwm_capture_if.slave)
//     coe_PWM_in   in   asynchronous PWM input conduit
//     irq          out  level interrupt = irq_en & (valid | timeout)
//     o_dbg_state  out  current measurement FSM state (state_e encoding)
//   Registers (word address):
//     0 PERIOD RO, 1 HIGH RO, 2 CONTROL RW {irq_en, enable},
//     3 STATUS RO/W1C {timeout, overrun, valid}, 4 TIMEOUT RW,
//     5 COUNT RO, 6/7 read zero.
// -----------------------------------------------------------------------------
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    pwm_capture_if.slave        avs,
    input  logic                coe_PWM_in,
    output logic                irq,
    output logic [1:0]          o_dbg_state
);

    localparam logic [1:0] S_IDLE      = ST_IDLE;
    localparam logic [1:0] S_WAIT_RISE = ST_WAIT_RISE;
    localparam logic [1:0] S_HIGH      = ST_HIGH;
    localparam logic [1:0] S_LOW       = ST_LOW;

    // ---------------------------------------------------------------------
    // Edge detection
    // ---------------------------------------------------------------------
    logic w_rise;
    logic w_fall;

    pwm_capture_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .i_pin  (coe_PWM_in),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [31:0] r_cnt;
    logic [31:0] r_hi_tmp;
    logic [31:0] r_idle_cnt;
    logic [31:0] r_period;
    logic [31:0] r_high;
    logic [31:0] r_timeout_val;
    logic [31:0] r_count;
    logic        r_enable;
    logic        r_irq_en;
    logic        r_valid;
    logic        r_overrun;
    logic        r_timeout;
    logic [31:0] r_readdata;

    // ---------------------------------------------------------------------
    // Bus decode
    // ---------------------------------------------------------------------
    logic       w_wr;
    logic       w_rd;
    logic       w_wr_ctrl;
    logic       w_wr_status;
    logic       w_wr_timeout;
    logic [2:0] w_w1c;

    assign w_wr         = avs.chipselect & avs.write;
    assign w_rd         = avs.chipselect & avs.read;
    assign w_wr_ctrl    = w_wr && (avs.address == ADDR_CONTROL);
    assign w_wr_status  = w_wr && (avs.address == ADDR_STATUS);
    assign w_wr_timeout = w_wr && (avs.address == ADDR_TIMEOUT);

    // STATUS clear mask; the status bits all live in byte lane 0.
    assign w_w1c = (w_wr_status && avs.byteenable[0]) ? avs.writedata[2:0] : 3'b000;

    // ---------------------------------------------------------------------
    // Measurement FSM and counters (next-state logic)
    // ---------------------------------------------------------------------
    logic        w_timeout_hit;
    logic [1:0]  w_state_nxt;
    logic [31:0] w_cnt_nxt;
    logic [31:0] w_hi_tmp_nxt;
    logic [31:0] w_idle_cnt_nxt;
    logic        w_result;
    logic        w_timeout_set;

    // The timeout compare is only meaningful while a measurement is live.
    assign w_timeout_hit = (r_timeout_val != 32'd0) &&
                           (r_idle_cnt == r_timeout_val) &&
                           (r_state != S_IDLE);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = sat_inc(r_cnt);
        w_hi_tmp_nxt  = r_hi_tmp;
        w_result      = 1'b0;
        w_timeout_set = 1'b0;

        if (!r_enable) begin
            // Disabling abandons any partial measurement; results are kept.
            w_state_nxt  = S_IDLE;
            w_cnt_nxt    = 32'd0;
            w_hi_tmp_nxt = 32'd0;
        end else if (r_state == S_IDLE) begin
            w_state_nxt  = S_WAIT_RISE;
            w_cnt_nxt    = 32'd0;
        end else if (w_timeout_hit) begin
            // Timeout takes precedence over an edge arriving the same cycle.
            w_state_nxt   = S_WAIT_RISE;
            w_cnt_nxt     = 32'd0;
            w_timeout_set = 1'b1;
        end else begin
            case (r_state)
                S_WAIT_RISE: begin
                    if (w_rise) begin
                        w_state_nxt = S_HIGH;
                        w_cnt_nxt   = 32'd1;
                    end
                end
                S_HIGH: begin
                    if (w_fall) begin
                        w_hi_tmp_nxt = r_cnt;
                        w_state_nxt  = S_LOW;
                    end
                end
                S_LOW: begin
                    if (w_rise) begin
                        w_result    = 1'b1;
                        w_cnt_nxt   = 32'd1;
                        w_state_nxt = S_HIGH;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 32'd0;
                end
            endcase
        end
    end

    always_comb begin
        if (!r_enable || (r_state == S_IDLE)) begin
            w_idle_cnt_nxt = 32'd0;
        end else if (w_rise || w_fall) begin
            w_idle_cnt_nxt = 32'd0;
        end else begin
            w_idle_cnt_nxt = sat_inc(r_idle_cnt);
        end
    end

    // ---------------------------------------------------------------------
    // Read mux
    // ---------------------------------------------------------------------
    logic [31:0] w_rd_mux;

    always_comb begin
        w_rd_mux = 32'd0;
        case (avs.address)
            ADDR_PERIOD:  w_rd_mux = r_period;
            ADDR_HIGH:    w_rd_mux = r_high;
            ADDR_CONTROL: w_rd_mux = {30'd0, r_irq_en, r_enable};
            ADDR_STATUS:  w_rd_mux = {29'd0, r_timeout, r_overrun, r_valid};
            ADDR_TIMEOUT: w_rd_mux = r_timeout_val;
            ADDR_COUNT:   w_rd_mux = r_count;
            default:      w_rd_mux = 32'd0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= 32'd0;
            r_hi_tmp      <= 32'd0;
            r_idle_cnt    <= 32'd0;
            r_period      <= 32'd0;
            r_high        <= 32'd0;
            r_timeout_val <= 32'd0;
            r_count       <= 32'd0;
            r_enable      <= 1'b0;
            r_irq_en      <= 1'b0;
            r_valid       <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout     <= 1'b0;
            r_readdata    <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_hi_tmp   <= w_hi_tmp_nxt;
            r_idle_cnt <= w_idle_cnt_nxt;

            if (w_result) begin
                r_period <= r_cnt;
                r_high   <= r_hi_tmp;
                r_count  <= r_count + 32'd1;
            end

            // Hardware set wins over a simultaneous software clear.
            r_valid   <= w_result | (r_valid & ~w_w1c[STAT_VALID]);
            r_overrun <= (w_result & r_valid) | (r_overrun & ~w_w1c[STAT_OVERRUN]);
            r_timeout <= w_timeout_set | (r_timeout & ~w_w1c[STAT_TIMEOUT]);

            if (w_wr_ctrl && avs.byteenable[0]) begin
                r_enable <= avs.writedata[CTRL_ENABLE];
                r_irq_en <= avs.writedata[CTRL_IRQ_EN];
            end

            if (w_wr_timeout) begin
                r_timeout_val <= apply_be(r_timeout_val, avs.writedata, avs.byteenable);
            end

            if (w_rd) begin
                r_readdata <= w_rd_mux;
            end
        end
    end

    assign avs.readdata = r_readdata;
    assign irq          = r_irq_en & (r_valid | r_timeout);
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;
  import pwm_capture_pkg::*;

  localparam int SYNC_STAGES = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pin = 1'b0;
  logic irq;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  pwm_capture_if bus();

  pwm_capture #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk         (clk),
    .reset       (reset),
    .avs         (bus.slave),
    .coe_PWM_in  (pin),
    .irq         (irq),
    .o_dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  // ---------------- PWM generator ----------------
  // Sole driver of the pin; changes it 1 time unit after posedge.
  logic gen_on = 1'b0;
  logic gen_level = 1'b0;
  int gen_hi = 100;
  int gen_per = 300;
  int gen_ph = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (gen_on) begin
        pin = (gen_ph < gen_hi);
        gen_ph = (gen_ph + 1 >= gen_per) ? 0 : gen_ph + 1;
      end else begin
        pin = gen_level;
        gen_ph = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a;
    bus.writedata = d; bus.byteenable = be;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write = 1'b0; bus.byteenable = 4'h0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.read = 1'b0;
    d = bus.readdata;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(1);
    checks++; if (bus.readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata: got %0h expected 0", bus.readdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_reg%0d: got %0h expected 0", a, rd); end
    end
  endtask

  task automatic test_measure();
    bus_write(ADDR_CONTROL, 32'd3, 4'hF);
    gen_hi = 100; gen_per = 300; gen_on = 1'b1;
    wait_cycles(450);
    bus_read(ADDR_PERIOD, rd);
    checks++; if (rd !== 32'd300) begin errors++; $display("FAIL measure_period: got %0d expected 300", rd); end
    bus_read(ADDR_HIGH, rd);
    checks++; if (rd !== 32'd100) begin errors++; $display("FAIL measure_high: got %0d expected 100", rd); end
    bus_read(ADDR_STATUS, rd);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL measure_status: got %0h expected 1", rd); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL measure_irq: got %b expected 1", irq); end
    bus_read(ADDR_COUNT, rd);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL measure_count1: got %0d expected 1", rd); end
  endtask

  task automatic test_overrun();
    wait_cycles(300);
    bus_read(ADDR_COUNT, rd);
    checks++; if (rd !== 32'd2) begin errors++; $display("FAIL overrun_count2: got %0d expected 2", rd); end
    bus_read(ADDR_STATUS, rd);
    checks++; if (rd !== 32'd3) begin errors++; $display("FAIL overrun_status: got %0h expected 3", rd); end
    bus_write(ADDR_STATUS, 32'd3, 4'hF);
    bus_read(ADDR_STATUS, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL overrun_clear: got %0h expected 0", rd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL overrun_irq_clear: got %b expected 0", irq); end
  endtask

  task automatic test_timeout();
    bus_write(ADDR_CONTROL, 32'd0, 4'hF);
    gen_on = 1'b0; gen_level = 1'b0;
    wait_cycles(10);
    bus_write(ADDR_STATUS, 32'd7, 4'hF);
    bus_write(ADDR_TIMEOUT, 32'd50, 4'hF);
    bus_write(ADDR_CONTROL, 32'd3, 4'hF);
    gen_level = 1'b1;
    wait_cycles(20);
    gen_level = 1'b0;
    wait_cycles(40);
    bus_read(ADDR_STATUS, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL timeout_early: got %0h expected 0", rd); end
    checks++; if (dbg_state !== ST_LOW) begin errors++; $display("FAIL timeout_low_state: got %0d expected 3", dbg_state); end
    wait_cycles(30);
    bus_read(ADDR_STATUS, rd);
    checks++; if (rd !== 32'd4) begin errors++; $display("FAIL timeout_status: got %0h expected 4", rd); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL timeout_irq: got %b expected 1", irq); end
    checks++; if (dbg_state !== ST_WAIT_RISE) begin errors++; $display("FAIL timeout_state: got %0d expected 1", dbg_state); end
    bus_read(ADDR_PERIOD, rd);
    checks++; if (rd !== 32'd300) begin errors++; $display("FAIL timeout_period_kept: got %0d expected 300", rd); end
    // Restart with phases shorter than the timeout.
    bus_write(ADDR_STATUS, 32'd4, 4'hF);
    gen_hi = 20; gen_per = 45; gen_on = 1'b1;
    wait_cycles(120);
    bus_read(ADDR_PERIOD, rd);
    checks++; if (rd !== 32'd45) begin errors++; $display("FAIL restart_period: got %0d expected 45", rd); end
    bus_read(ADDR_HIGH, rd);
    checks++; if (rd !== 32'd20) begin errors++; $display("FAIL restart_high: got %0d expected 20", rd); end
    bus_read(ADDR_STATUS, rd);
    checks++; if ((rd & 32'd5) !== 32'd1) begin errors++; $display("FAIL restart_status: got %0h expected valid set, timeout clear", rd); end
  endtask

  task automatic test_duty_extremes();
    bus_write(ADDR_CONTROL, 32'd0, 4'hF);
    gen_on = 1'b0; gen_level = 1'b0;
    wait_cycles(5);
    bus_write(ADDR_TIMEOUT, 32'd0, 4'hF);
    bus_write(ADDR_STATUS, 32'd7, 4'hF);
    gen_hi = 1; gen_per = 2;
    bus_write(ADDR_CONTROL, 32'd1, 4'hF);
    gen_on = 1'b1;
    wait_cycles(20);
    bus_read(ADDR_PERIOD, rd);
    checks++; if (rd !== 32'd2) begin errors++; $display("FAIL narrow_period: got %0d expected 2", rd); end
    bus_read(ADDR_HIGH, rd);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL narrow_high: got %0d expected 1", rd); end
    bus_write(ADDR_CONTROL, 32'd0, 4'hF);
    gen_on = 1'b0;
    wait_cycles(5);
    gen_hi = 299; gen_per = 300;
    bus_write(ADDR_CONTROL, 32'd1, 4'hF);
    gen_on = 1'b1;
    wait_cycles(700);
    bus_read(ADDR_PERIOD, rd);
    checks++; if (rd !== 32'd300) begin errors++; $display("FAIL wide_period: got %0d expected 300", rd); end
    bus_read(ADDR_HIGH, rd);
    checks++; if (rd !== 32'd299) begin errors++; $display("FAIL wide_high: got %0d expected 299", rd); end
  endtask

  task automatic test_disable_mid();
    @(negedge clk);
    reset = 1'b1; gen_on = 1'b0; gen_level = 1'b0;
    wait_cycles(2);
    reset = 1'b0;
    bus_write(ADDR_CONTROL, 32'd1, 4'hF);
    gen_hi = 100; gen_per = 300; gen_on = 1'b1;
    wait_cycles(50);
    bus_write(ADDR_CONTROL, 32'd0, 4'hF);
    gen_on = 1'b0;
    wait_cycles(400);
    bus_read(ADDR_COUNT, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL disable_count: got %0d expected 0", rd); end
    bus_read(ADDR_PERIOD, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL disable_period: got %0d expected 0", rd); end
    bus_read(ADDR_STATUS, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL disable_status: got %0h expected 0", rd); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL disable_state: got %0d expected 0", dbg_state); end
    bus_write(ADDR_CONTROL, 32'd1, 4'hF);
    gen_on = 1'b1;
    wait_cycles(250);
    bus_read(ADDR_COUNT, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reenable_early_count: got %0d expected 0", rd); end
    wait_cycles(100);
    bus_read(ADDR_COUNT, rd);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL reenable_count: got %0d expected 1", rd); end
    bus_read(ADDR_PERIOD, rd);
    checks++; if (rd !== 32'd300) begin errors++; $display("FAIL reenable_period: got %0d expected 300", rd); end
    bus_read(ADDR_HIGH, rd);
    checks++; if (rd !== 32'd100) begin errors++; $display("FAIL reenable_high: got %0d expected 100", rd); end
  endtask

  task automatic test_bus_misc();
    bus_write(ADDR_CONTROL, 32'd0, 4'b0000);
    bus_read(ADDR_CONTROL, rd);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL ctrl_be0: got %0h expected 1", rd); end
    bus_write(ADDR_CONTROL, 32'hFFFF_FFFF, 4'hF);
    bus_read(ADDR_CONTROL, rd);
    checks++; if (rd !== 32'd3) begin errors++; $display("FAIL ctrl_upper_zero: got %0h expected 3", rd); end
    bus_write(ADDR_CONTROL, 32'd0, 4'b1110);
    bus_read(ADDR_CONTROL, rd);
    checks++; if (rd !== 32'd3) begin errors++; $display("FAIL ctrl_lane0_off: got %0h expected 3", rd); end
    bus_write(ADDR_CONTROL, 32'd2, 4'b0001);
    bus_read(ADDR_CONTROL, rd);
    checks++; if (rd !== 32'd2) begin errors++; $display("FAIL ctrl_lane0_on: got %0h expected 2", rd); end
    bus_write(ADDR_TIMEOUT, 32'h1234_5678, 4'hF);
    bus_write(ADDR_TIMEOUT, 32'hAABB_CCDD, 4'b0101);
    bus_read(ADDR_TIMEOUT, rd);
    checks++; if (rd !== 32'h12BB_56DD) begin errors++; $display("FAIL timeout_be: got %0h expected 12bb56dd", rd); end
    wait_cycles(3);
    checks++; if (bus.readdata !== 32'h12BB_56DD) begin errors++; $display("FAIL readdata_hold: got %0h expected 12bb56dd", bus.readdata); end
    bus_write(3'd6, 32'hFFFF_FFFF, 4'hF);
    bus_read(3'd6, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL addr6: got %0h expected 0", rd); end
    bus_read(3'd7, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL addr7: got %0h expected 0", rd); end
    bus_write(ADDR_TIMEOUT, 32'd0, 4'hF);
  endtask

  task automatic test_reset_mid();
    gen_on = 1'b0; gen_level = 1'b0;
    bus_write(ADDR_STATUS, 32'd7, 4'hF);
    bus_write(ADDR_CONTROL, 32'd3, 4'hF);
    wait_cycles(5);
    gen_hi = 100; gen_per = 300; gen_on = 1'b1;
    wait_cycles(450);
    checks++; if (dbg_state !== ST_LOW) begin errors++; $display("FAIL rstmid_in_low: got %0d expected 3", dbg_state); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rstmid_irq_before: got %b expected 1", irq); end
    reset = 1'b1; gen_on = 1'b0;
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rstmid_irq: got %b expected 0", irq); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rstmid_state: got %0d expected 0", dbg_state); end
    checks++; if (bus.readdata !== 32'd0) begin errors++; $display("FAIL rstmid_readdata: got %0h expected 0", bus.readdata); end
    reset = 1'b0;
    for (int a = 0; a < 6; a++) begin
      bus_read(3'(a), rd);
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rstmid_reg%0d: got %0h expected 0", a, rd); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
    bus.address = 3'd0; bus.writedata = 32'd0; bus.byteenable = 4'h0;
    test_reset();
    test_measure();
    test_overrun();
    test_timeout();
    test_duty_extremes();
    test_disable_mid();
    test_bus_misc();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Avalon-MM slave that measures an external PWM signal: period and high time in `clk` cycles, rise-to-rise. It is the receive-side counterpart of the PWM generator on the Lidar/motor fabric. Use it to read back servo/encoder PWM or to loop-check the generator output. It sits on the HPS lightweight bridge beside the generator and uses the same 32-bit register programming model.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops on `coe_PWM_in`; minimum 2.
- `clk`  in  1: single system clock.
- `reset`  in  1: synchronous, active-high reset. Sampled on the rising edge of `clk`.
- `chipselect`  in  1: slave select.
- `address`  in  3: word address.
- `write`  in  1: write strobe.
- `writedata`  in  32: write data.
- `read`  in  1: read strobe.
- `byteenable`  in  4: byte lanes for writes to RW registers.
- `readdata`  out  32: registered read data.
- `coe_PWM_in`  in  1: asynchronous PWM input (conduit).
- `irq`  out  1: level interrupt.

## Operation
Register map (word address):
- 0 PERIOD (RO): rise-to-rise clocks of the last complete cycle.
- 1 HIGH (RO): rise-to-fall clocks of the same cycle.
- 2 CONTROL (RW): bit0 `enable`, bit1 `irq_en`; other bits read 0.
- 3 STATUS (RO, W1C): bit0 `valid` (new result), bit1 `overrun` (result replaced while `valid`=1), bit2 `timeout`.
- 4 TIMEOUT (RW): clocks without any edge before `timeout` sets; 0 disables the timeout.
- 5 COUNT (RO): number of completed measurements; 32-bit, wraps.
- 6, 7: read 32'h0; writes are ignored.

Behaviour:
- All RW registers honour `byteenable` per byte.
- `irq` = `irq_en & (valid | timeout)`.
- FSM states: IDLE, WAIT_RISE, HIGH, LOW.
  - IDLE: entered when `enable`=0 (from any state). Counters clear. Result registers hold their values.
  - IDLE→WAIT_RISE when `enable`=1.
  - WAIT_RISE→HIGH on a rise pulse; `cnt` := 1.
  - HIGH: on a fall pulse, `hi_tmp` := `cnt`, go to LOW.
  - LOW: on a rise pulse, PERIOD := `cnt`, HIGH := `hi_tmp`, `valid` := 1, COUNT += 1. If `valid` was already 1, `overrun` := 1. Then `cnt` := 1 and go to HIGH.
  - Otherwise `cnt` increments every clock and saturates at 32'hFFFF_FFFF.
- Timeout: `idle_cnt` clears on any edge pulse and increments otherwise. When TIMEOUT≠0 and `idle_cnt` = TIMEOUT in state HIGH, LOW or WAIT_RISE: `timeout` := 1, FSM → WAIT_RISE, partial measurement discarded.
- Simultaneous hardware set and software W1C of the same STATUS bit: the set wins.
- Rise and fall pulses in the same cycle cannot occur; the edge detector emits at most one.

## Timing
- Reset values:
  - `readdata` = 0, `irq` = 0.
  - All registers = 0; FSM = IDLE.
  - Synchronizer flops = 0.
- Input latency: a pin change produces an edge pulse `SYNC_STAGES`+1 clocks later. Both edges share this latency, so measured widths are exact in clocks.
- Result update: PERIOD, HIGH, `valid` and COUNT are visible in the cycle after the rise pulse. `irq` is high that same cycle.
- Reads: `readdata` is valid one clock after `read & chipselect` (read latency 1). It holds its value otherwise.
- Writes take effect on the clock edge where `write & chipselect` is high.
- Clearing `enable` mid-measurement: IDLE on the next clock, no result written.
- Reset mid-measurement: same clock returns all state to reset values.
- Minimum measurable pulse: 1 clock high or low, after synchronization.

## Structure
- Package `pwm_capture_pkg` contains:
  - register address constants (`ADDR_PERIOD`…`ADDR_COUNT`);
  - STATUS and CONTROL bit indices;
  - FSM state enum.
- Sub-module `pwm_capture_sync`: `SYNC_STAGES` synchronizer plus edge detector, outputting `rise`/`fall` pulses. The top level holds the register file, the FSM and the counters.

## Test plan
- Enable, drive a 100-high/300-period square wave → after the second rising edge PERIOD=300, HIGH=100, STATUS=1, `irq`=1 when `irq_en`=1; COUNT increments by 1 per period.
- Do not clear `valid` across two periods → STATUS=3 (`overrun`). Write 3 to STATUS → STATUS=0 and `irq`=0.
- TIMEOUT=50, stop the input low after one rise → `timeout` sets when `idle_cnt`=50 (see Operation), FSM returns to WAIT_RISE, PERIOD unchanged. Restart the input → new valid result.
- Duty extremes: 1-high/2-period → PERIOD=2, HIGH=1. 299-high/300-period → HIGH=299.
- Clear `enable` in the middle of the high phase → no result, COUNT unchanged. Re-enable and drive the input → the first result appears only after a full rise-fall-rise.
- Write CONTROL with `byteenable`=4'b0000 → unchanged. Read address 6 → 0. Assert `reset` during LOW → all registers 0 and `irq`=0 on the next clock.
